// File: rtl/display_pkg.sv
// Shared definitions for the display arbiter: blank word, source indices,
// FSM encoding and the round-robin search helper.
package display_pkg;

  localparam logic [31:0] BLANK_WORD = 32'hFFFF_FFFF;
  localparam int          N_SRC      = 4;
  localparam int          ALARM_IDX  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALARM = 2'd2
  } state_t;

  function automatic logic [N_SRC-1:0] src_onehot(input logic [1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Search status sources 1..3 starting after 'last', wrapping 3 -> 1.
  // Bit 0 of reqs is ignored; returns 0 when nothing is requesting.
  function automatic logic [1:0] rr_pick(input logic [N_SRC-1:0] reqs,
                                         input logic [1:0]       last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idx = 2'((int'(last) + i) % 3 + 1);
      if (!found && reqs[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick enable every TICK_DIV clk cycles,
// so all timing logic stays on the single clock.
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 8-digit BCD display between a blinking, preempting alarm
// (source 0) and three round-robin status sources with a minimum hold time.
module display_arbiter
  import display_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int MIN_HOLD   = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    req,
  input  logic [32*N_SRC-1:0] req_data,
  output logic [31:0]         disp_data,
  output logic [N_SRC-1:0]    grant,
  output logic                blink_on
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  if (MIN_HOLD < 1) begin : g_bad_hold
    $error("MIN_HOLD must be >= 1");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be >= 1");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2");
  end

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_t           state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [31:0]      disp_q, disp_d;
  logic             blink_q, blink_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       cur_q, cur_d;

  logic [N_SRC-1:0] status_req;
  logic [N_SRC-1:0] others;
  logic [1:0]       pick;
  logic             hold_done;
  logic             go_alarm, go_show, go_idle;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    disp_d   = disp_q;
    blink_d  = blink_q;
    hold_d   = hold_q;
    bcnt_d   = bcnt_q;
    rr_d     = rr_q;
    cur_d    = cur_q;
    go_alarm = 1'b0;
    go_show  = 1'b0;
    go_idle  = 1'b0;

    status_req = {req[N_SRC-1:1], 1'b0};
    others     = status_req & ~src_onehot(cur_q);
    hold_done  = (hold_q == HW'(MIN_HOLD));
    // A rotation away from the shown source must not pick it again.
    pick       = rr_pick((state_q == SHOW) ? others : status_req, rr_q);

    unique case (state_q)
      IDLE: begin
        if (req[ALARM_IDX])  go_alarm = 1'b1;
        else if (|status_req) go_show = 1'b1;
        else                  go_idle = 1'b1;
      end

      SHOW: begin
        if (req[cur_q]) disp_d = req_data[32*cur_q +: 32];
        if (tick && !hold_done) hold_d = hold_q + 1'b1;

        if (req[ALARM_IDX])                go_alarm = 1'b1;
        else if (hold_done && |others)     go_show  = 1'b1;
        else if (hold_done && !req[cur_q]) go_idle  = 1'b1;
      end

      ALARM: begin
        if (!req[ALARM_IDX]) begin
          // Leave the alarm straight into whatever IDLE would choose.
          if (|status_req) go_show = 1'b1;
          else             go_idle = 1'b1;
        end else begin
          if (tick) begin
            if (bcnt_q == BW'(BLINK_HALF - 1)) begin
              bcnt_d  = '0;
              blink_d = !blink_q;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
          disp_d = blink_d ? req_data[31:0] : BLANK_WORD;
        end
      end

      default: go_idle = 1'b1;
    endcase

    if (go_alarm) begin
      state_d = ALARM;
      grant_d = src_onehot(2'(ALARM_IDX));
      blink_d = 1'b1;
      bcnt_d  = '0;
      disp_d  = req_data[31:0];
    end else if (go_show) begin
      state_d = SHOW;
      cur_d   = pick;
      rr_d    = pick;
      grant_d = src_onehot(pick);
      disp_d  = req_data[32*pick +: 32];
      hold_d  = '0;
      blink_d = 1'b0;
    end else if (go_idle) begin
      state_d = IDLE;
      grant_d = '0;
      disp_d  = BLANK_WORD;
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      disp_q  <= BLANK_WORD;
      blink_q <= 1'b0;
      hold_q  <= '0;
      bcnt_q  <= '0;
      rr_q    <= 2'd3;
      cur_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      disp_q  <= disp_d;
      blink_q <= blink_d;
      hold_q  <= hold_d;
      bcnt_q  <= bcnt_d;
      rr_q    <= rr_d;
      cur_q   <= cur_d;
    end
  end

  assign disp_data = disp_q;
  assign grant     = grant_q;
  assign blink_on  = blink_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with TICK_DIV=4, MIN_HOLD=3, BLINK_HALF=2.
// Ticks are consumed at edges 4, 8, 12, ... counted from the last reset edge.
module tb_display_arbiter;
  import display_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [31:0]  disp_data;
  logic [3:0]   grant;
  logic         blink_on;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  display_arbiter #(
    .TICK_DIV   (4),
    .MIN_HOLD   (3),
    .BLINK_HALF (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .disp_data (disp_data),
    .grant     (grant),
    .blink_on  (blink_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g,
                           input logic [31:0] d, input logic b);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".disp"}, disp_data, d);
    check({tag, ".blink"}, 32'(blink_on), 32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic run_to(input int target);
    while (n_cyc < target) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst   = 1'b0;
    n_cyc = 0;
  endtask

  task automatic set_src(input int idx, input logic [31:0] v);
    req_data[32*idx +: 32] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    req      = 4'b0000;
    req_data = '0;

    // Idle after reset
    do_reset();
    check_out("reset", 4'b0000, BLANK_WORD, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step();
      check_out("idle", 4'b0000, BLANK_WORD, 1'b0);
    end

    // Single requester, one-cycle latency and data following
    do_reset();
    set_src(2, 32'h0000_1234);
    req = 4'b0100;
    check("pre_edge.grant", 32'(grant), 32'h0);
    step();
    check_out("grant2", 4'b0100, 32'h0000_1234, 1'b0);
    set_src(2, 32'h0000_5678);
    check("follow_pre.disp", disp_data, 32'h0000_1234);
    step();
    check("follow.disp", disp_data, 32'h0000_5678);

    // Round robin between sources 1 and 3 from rr_last=3
    req = 4'b1010;
    set_src(1, 32'h0000_0011);
    set_src(2, 32'h0000_0022);
    set_src(3, 32'h0000_0033);
    do_reset();
    step();
    check_out("rr_first", 4'b0010, 32'h0000_0011, 1'b0);
    run_to(12);
    check_out("rr_hold1", 4'b0010, 32'h0000_0011, 1'b0);
    step();
    check_out("rr_switch3", 4'b1000, 32'h0000_0033, 1'b0);
    run_to(24);
    check_out("rr_hold3", 4'b1000, 32'h0000_0033, 1'b0);
    step();
    check_out("rr_back1", 4'b0010, 32'h0000_0011, 1'b0);

    // Alarm preempts source 1 at hold_cnt=1, blinks, then hands back by RR
    run_to(28);
    set_src(0, 32'h0000_0911);
    req = 4'b1011;
    step();
    check_out("alarm_entry", 4'b0001, 32'h0000_0911, 1'b1);
    run_to(35);
    check_out("alarm_on_end", 4'b0001, 32'h0000_0911, 1'b1);
    step();
    check_out("alarm_off", 4'b0001, BLANK_WORD, 1'b0);
    run_to(43);
    check_out("alarm_off_end", 4'b0001, BLANK_WORD, 1'b0);
    step();
    check_out("alarm_on2", 4'b0001, 32'h0000_0911, 1'b1);
    req = 4'b1010;
    step();
    check_out("alarm_exit", 4'b1000, 32'h0000_0033, 1'b0);

    // Source 3 alone drops after one tick: freeze until hold expires
    req = 4'b1000;
    run_to(48);
    check_out("solo", 4'b1000, 32'h0000_0033, 1'b0);
    req = 4'b0000;
    set_src(3, 32'h0000_0099);
    step();
    check_out("freeze", 4'b1000, 32'h0000_0033, 1'b0);
    run_to(56);
    check_out("freeze_end", 4'b1000, 32'h0000_0033, 1'b0);
    step();
    check_out("release", 4'b0000, BLANK_WORD, 1'b0);

    // Reset in the middle of an alarm restarts the prescaler
    req = 4'b0001;
    step();
    check_out("alarm2", 4'b0001, 32'h0000_0911, 1'b1);
    run_to(61);
    rst = 1'b1;
    step();
    check_out("mid_reset", 4'b0000, BLANK_WORD, 1'b0);
    rst   = 1'b0;
    n_cyc = 0;
    step();
    check_out("alarm3", 4'b0001, 32'h0000_0911, 1'b1);
    run_to(7);
    check_out("alarm3_on_end", 4'b0001, 32'h0000_0911, 1'b1);
    step();
    check_out("alarm3_off", 4'b0001, BLANK_WORD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
